mpram_write_arbiter: RTL and testbench



---
 rtl/mpram_pkg.sv | 25 ++
 rtl/mpram_write_arbiter_if.sv | 37 +++
 rtl/mpram_wr_pick.sv | 86 ++++++++
 rtl/mpram_write_arbiter.sv | 98 +++++++++
 tb/tb_mpram_write_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mpram_pkg.sv
// Shared types and constants for the multi-port RAM write arbiter.
// Default geometry lives here so the interface, arbiter and request struct agree.
package mpram_pkg;

    localparam int DEF_DATA_DEPTH       = 128;
    localparam int DEF_DATA_WIDTH       = 64;
    localparam int DEF_BYTE_WRITE_WIDTH = 64;
    localparam int DEF_REQ_NUM          = 8;
    localparam int DEF_WPORTS_NUM       = 4;
    localparam int DEF_ADDR_WIDTH       = $clog2(DEF_DATA_DEPTH);
    localparam int DEF_BYTES_NUM        = DEF_DATA_WIDTH / DEF_BYTE_WRITE_WIDTH;
    localparam int CNT_W                = 32;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_BYTES_NUM-1:0]  we;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wr_req_t;

    // Width of an index into n items; never zero so a single requester still works.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpram_write_arbiter_if.sv
// Requester-side handshake and RAM write-port bus of the write arbiter.
// The arbiter connects through the slave modport; the requester/RAM environment uses master.
interface mpram_write_arbiter_if
    import mpram_pkg::*;
#(
    parameter int DATA_DEPTH       = DEF_DATA_DEPTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int BYTE_WRITE_WIDTH = DEF_BYTE_WRITE_WIDTH,
    parameter int REQ_NUM          = DEF_REQ_NUM,
    parameter int WPORTS_NUM       = DEF_WPORTS_NUM
);
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int BYTES_NUM  = DATA_WIDTH / BYTE_WRITE_WIDTH;

    logic [REQ_NUM-1:0]                    req_valid_i;
    logic [REQ_NUM-1:0]                    req_ready_o;
    logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]    req_addr_i;
    logic [REQ_NUM-1:0][BYTES_NUM-1:0]     req_we_i;
    logic [REQ_NUM-1:0][DATA_WIDTH-1:0]    req_data_i;

    logic [WPORTS_NUM-1:0]                 ram_en_w_o;
    logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  ram_we_o;
    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] ram_waddr_o;
    logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] ram_data_o;
    logic [CNT_W-1:0]                      conflict_cnt_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_data_i,
        input  req_ready_o, ram_en_w_o, ram_we_o, ram_waddr_o, ram_data_o, conflict_cnt_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_data_i,
        output req_ready_o, ram_en_w_o, ram_we_o, ram_waddr_o, ram_data_o, conflict_cnt_o
    );

endinterface

// File: rtl/mpram_wr_pick.sv
// Combinational round-robin pick: grants up to WPORTS_NUM valid requests with pairwise
// distinct addresses, packs them onto ports in scan order and computes the next pointer.
module mpram_wr_pick
    import mpram_pkg::*;
#(
    parameter int REQ_NUM    = DEF_REQ_NUM,
    parameter int WPORTS_NUM = DEF_WPORTS_NUM,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int PTR_W     = ptr_width(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]                 valid_i,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [PTR_W-1:0]                   rr_ptr_i,
    output logic [REQ_NUM-1:0]                 grant_o,
    output logic [WPORTS_NUM-1:0]              port_used_o,
    output logic [WPORTS_NUM-1:0][PTR_W-1:0]   port_src_o,
    output logic                               conflict_o,
    output logic [PTR_W-1:0]                   rr_ptr_next_o
);

    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] granted_addr;
    logic                                  addr_hit;
    int                                    n_granted;
    int                                    idx;
    int                                    first_loser;
    int                                    last_grant;
    int                                    after_last;

    always_comb begin
        grant_o      = '0;
        port_used_o  = '0;
        port_src_o   = '0;
        conflict_o   = 1'b0;
        granted_addr = '0;
        addr_hit     = 1'b0;
        n_granted    = 0;
        idx          = 0;
        first_loser  = -1;
        last_grant   = 0;

        for (int s = 0; s < REQ_NUM; s++) begin
            idx = int'(rr_ptr_i) + s;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (valid_i[idx]) begin
                addr_hit = 1'b0;
                for (int k = 0; k < WPORTS_NUM; k++) begin
                    if (k < n_granted && granted_addr[k] == addr_i[idx]) begin
                        addr_hit = 1'b1;
                    end
                end
                if (!addr_hit && n_granted < WPORTS_NUM) begin
                    grant_o[idx] = 1'b1;
                    for (int k = 0; k < WPORTS_NUM; k++) begin
                        if (k == n_granted) begin
                            port_used_o[k]  = 1'b1;
                            port_src_o[k]   = PTR_W'(idx);
                            granted_addr[k] = addr_i[idx];
                        end
                    end
                    last_grant = idx;
                    n_granted  = n_granted + 1;
                end else begin
                    // An address clash is reported even when the ports were already full.
                    if (first_loser < 0) begin
                        first_loser = idx;
                    end
                    if (addr_hit) begin
                        conflict_o = 1'b1;
                    end
                end
            end
        end

        after_last = (last_grant + 1 == REQ_NUM) ? 0 : last_grant + 1;
        if (valid_i == '0) begin
            rr_ptr_next_o = rr_ptr_i;
        end else if (first_loser >= 0) begin
            rr_ptr_next_o = PTR_W'(first_loser);
        end else begin
            rr_ptr_next_o = PTR_W'(after_last);
        end
    end

endmodule

// File: rtl/mpram_write_arbiter.sv
// Write-port arbiter for the multi-port RAM: shares WPORTS_NUM write ports among REQ_NUM
// requesters, never issuing two same-address writes in one cycle; RAM outputs are registered.
module mpram_write_arbiter
    import mpram_pkg::*;
#(
    parameter int DATA_DEPTH       = DEF_DATA_DEPTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int BYTE_WRITE_WIDTH = DEF_BYTE_WRITE_WIDTH,
    parameter int REQ_NUM          = DEF_REQ_NUM,
    parameter int WPORTS_NUM       = DEF_WPORTS_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    mpram_write_arbiter_if.slave  arb_if
);

    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int BYTES_NUM  = DATA_WIDTH / BYTE_WRITE_WIDTH;
    localparam int PTR_W      = ptr_width(REQ_NUM);

    logic [PTR_W-1:0]                      rr_ptr_q;
    logic [PTR_W-1:0]                      rr_ptr_d;
    logic [REQ_NUM-1:0]                    valid_gated;
    logic [REQ_NUM-1:0]                    grant;
    logic [WPORTS_NUM-1:0]                 port_used;
    logic [WPORTS_NUM-1:0][PTR_W-1:0]      port_src;
    logic                                  conflict;

    logic [WPORTS_NUM-1:0]                 en_q,   en_d;
    logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_q,   we_d;
    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]                      cnt_q,  cnt_d;

    // Masking valid during reset keeps ready low and the pointer/counter untouched.
    assign valid_gated = rst ? '0 : arb_if.req_valid_i;

    mpram_wr_pick #(
        .REQ_NUM    (REQ_NUM),
        .WPORTS_NUM (WPORTS_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pick (
        .valid_i       (valid_gated),
        .addr_i        (arb_if.req_addr_i),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .port_used_o   (port_used),
        .port_src_o    (port_src),
        .conflict_o    (conflict),
        .rr_ptr_next_o (rr_ptr_d)
    );

    assign arb_if.req_ready_o = grant;

    // Idle ports drop enable and mask but keep their last address and data.
    for (genvar gi = 0; gi < WPORTS_NUM; gi++) begin : g_port
        assign en_d[gi]   = port_used[gi];
        assign we_d[gi]   = port_used[gi] ? arb_if.req_we_i[port_src[gi]]   : '0;
        assign addr_d[gi] = port_used[gi] ? arb_if.req_addr_i[port_src[gi]] : addr_q[gi];
        assign data_d[gi] = port_used[gi] ? arb_if.req_data_i[port_src[gi]] : data_q[gi];
    end

    assign cnt_d = (conflict && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            en_q     <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign arb_if.ram_en_w_o     = en_q;
    assign arb_if.ram_we_o       = we_q;
    assign arb_if.ram_waddr_o    = addr_q;
    assign arb_if.ram_data_o     = data_q;
    assign arb_if.conflict_cnt_o = cnt_q;

`ifdef DEBUG
    always @(posedge clk) begin
        assert (REQ_NUM >= WPORTS_NUM && WPORTS_NUM > 0)
            else $error("mpram_write_arbiter: need REQ_NUM >= WPORTS_NUM > 0");
        assert (DATA_WIDTH % BYTE_WRITE_WIDTH == 0)
            else $error("mpram_write_arbiter: DATA_WIDTH not a multiple of BYTE_WRITE_WIDTH");
    end
`endif

endmodule

// File: tb/tb_mpram_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based
// reference model of the round-robin, address-distinct write arbitration.
module tb_mpram_write_arbiter;
    import mpram_pkg::*;

    localparam int REQ = 8;
    localparam int WP  = 4;
    localparam int AW  = 7;
    localparam int BN  = 1;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpram_write_arbiter_if #(
        .DATA_DEPTH(128), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(64), .REQ_NUM(REQ), .WPORTS_NUM(WP)
    ) bus ();

    mpram_write_arbiter #(
        .DATA_DEPTH(128), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(64), .REQ_NUM(REQ), .WPORTS_NUM(WP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int                    m_rr = 0;
    logic [WP-1:0]         m_en = '0;
    logic [WP-1:0][BN-1:0] m_we = '0;
    logic [WP-1:0][AW-1:0] m_addr = '0;
    logic [WP-1:0][DW-1:0] m_data = '0;
    logic [31:0]           m_cnt = '0;

    logic [REQ-1:0] exp_ready;
    logic [REQ-1:0] act_ready;
    int             exp_src[$];
    bit             exp_conf;
    int             exp_rr;
    int             exp_loser;
    int             promoted = -1;

    task automatic model_pick();
        bit clash;
        int i;
        exp_ready = '0;
        exp_src.delete();
        exp_conf  = 0;
        exp_rr    = m_rr;
        exp_loser = -1;
        if (rst) return;
        for (int s = 0; s < REQ; s++) begin
            i = (m_rr + s) % REQ;
            if (bus.req_valid_i[i]) begin
                clash = 0;
                foreach (exp_src[j])
                    if (bus.req_addr_i[exp_src[j]] == bus.req_addr_i[i]) clash = 1;
                if (!clash && exp_src.size() < WP) begin
                    exp_src.push_back(i);
                    exp_ready[i] = 1'b1;
                end else begin
                    if (exp_loser < 0) exp_loser = i;
                    if (clash) exp_conf = 1;
                end
            end
        end
        if (exp_loser >= 0) exp_rr = exp_loser;
        else if (exp_src.size() > 0) exp_rr = (exp_src[exp_src.size()-1] + 1) % REQ;
    endtask

    task automatic cycle();
        logic rst_s;
        @(negedge clk);
        model_pick();
        act_ready = bus.req_ready_o;
        check_eq("ready", act_ready, exp_ready);
        if (promoted >= 0 && !rst && bus.req_valid_i[promoted])
            check_eq("promoted_grant", act_ready[promoted], 1'b1);
        rst_s = rst;
        if (rst_s) begin
            m_rr = 0; m_en = '0; m_we = '0; m_addr = '0; m_data = '0; m_cnt = '0;
            promoted = -1;
        end else begin
            for (int k = 0; k < WP; k++) begin
                if (k < exp_src.size()) begin
                    m_en[k]   = 1'b1;
                    m_we[k]   = bus.req_we_i[exp_src[k]];
                    m_addr[k] = bus.req_addr_i[exp_src[k]];
                    m_data[k] = bus.req_data_i[exp_src[k]];
                end else begin
                    m_en[k] = 1'b0;
                    m_we[k] = '0;
                end
            end
            if (exp_conf && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_rr     = exp_rr;
            promoted = exp_loser;
        end
        @(posedge clk);
        #1;
        n_cyc++;
        check_eq("ram_en",   bus.ram_en_w_o,     m_en);
        check_eq("ram_we",   bus.ram_we_o,       m_we);
        check_eq("ram_addr", bus.ram_waddr_o,    m_addr);
        check_eq("ram_data", bus.ram_data_o,     m_data);
        check_eq("conf_cnt", bus.conflict_cnt_o, m_cnt);
        $display("cyc %0d rst=%0b valid=%b ready=%b en=%b cnt=%0d",
                 n_cyc, rst_s, bus.req_valid_i, act_ready, bus.ram_en_w_o, bus.conflict_cnt_o);
    endtask

    task automatic set_req(input int i, input int a, input logic [63:0] d);
        bus.req_valid_i[i] = 1'b1;
        bus.req_addr_i[i]  = AW'(a);
        bus.req_we_i[i]    = 1'b1;
        bus.req_data_i[i]  = d;
    endtask

    task automatic clear_all();
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_we_i    = '0;
        bus.req_data_i  = '0;
    endtask

    task automatic retire_granted();
        for (int i = 0; i < REQ; i++)
            if (exp_ready[i]) bus.req_valid_i[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        cycle();
        rst = 1'b0;
    endtask

    task automatic new_req(input int i);
        bus.req_valid_i[i] = ($urandom_range(0, 1) == 1);
        bus.req_addr_i[i]  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 127))
                                                          : AW'($urandom_range(0, 7));
        bus.req_we_i[i]    = BN'($urandom_range(0, 1));
        bus.req_data_i[i]  = {$urandom, $urandom};
    endtask

    initial begin
        // 1: reset with all requesters valid
        clear_all();
        for (int i = 0; i < REQ; i++) set_req(i, i + 16, 64'(i));
        rst = 1'b1;
        repeat (3) cycle();
        check_eq("t1_cnt_reset", bus.conflict_cnt_o, 32'd0);
        rst = 1'b0;
        clear_all();
        cycle();
        check_eq("t1_en_idle", bus.ram_en_w_o, 4'b0000);

        // 2: sparse requests from pointer 0
        do_reset();
        set_req(0, 8'h01, 64'hA0); set_req(2, 8'h02, 64'hA2); set_req(5, 8'h03, 64'hA5);
        cycle();
        check_eq("t2_ready", act_ready, 8'b0010_0101);
        check_eq("t2_en", bus.ram_en_w_o, 4'b0111);
        check_eq("t2_addr", bus.ram_waddr_o[2:0], {7'h03, 7'h02, 7'h01});
        retire_granted();

        // 3: all requesters, distinct addresses
        do_reset();
        for (int i = 0; i < REQ; i++) set_req(i, 8'h40 + i, 64'h300 + 64'(i));
        cycle();
        check_eq("t3_first", act_ready, 8'h0F);
        retire_granted();
        cycle();
        check_eq("t3_second", act_ready, 8'hF0);
        check_eq("t3_cnt", bus.conflict_cnt_o, 32'd0);
        retire_granted();

        // 4: same-address pair serialised
        do_reset();
        set_req(1, 8'h10, 64'hD1); set_req(5, 8'h10, 64'hD5);
        cycle();
        check_eq("t4_ready1", act_ready, 8'b0000_0010);
        check_eq("t4_cnt", bus.conflict_cnt_o, 32'd1);
        check_eq("t4_data1", bus.ram_data_o[0], 64'hD1);
        retire_granted();
        cycle();
        check_eq("t4_ready5", act_ready, 8'b0010_0000);
        check_eq("t4_data5", bus.ram_data_o[0], 64'hD5);
        check_eq("t4_addr5", bus.ram_waddr_o[0], 7'h10);
        retire_granted();

        // 5: req 0 keeps hammering the address req 2 waits on
        do_reset();
        set_req(0, 8'h20, 64'hE0); set_req(2, 8'h20, 64'hE2);
        cycle();
        set_req(0, 8'h20, 64'hE1);
        cycle();
        check_eq("t5_req2_served", act_ready[2], 1'b1);
        clear_all();

        // 6: reset right after an issue
        do_reset();
        set_req(3, 8'h7F, 64'hF3);
        cycle();
        check_eq("t6_issued", bus.ram_en_w_o, 4'b0001);
        retire_granted();
        rst = 1'b1;
        cycle();
        check_eq("t6_cleared", bus.ram_en_w_o, 4'b0000);
        rst = 1'b0;
        set_req(0, 8'h05, 64'hF0); set_req(3, 8'h7F, 64'hF4);
        cycle();
        check_eq("t6_order", bus.ram_waddr_o[1:0], {7'h7F, 7'h05});
        clear_all();

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < REQ; i++) new_req(i);
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            cycle();
            for (int i = 0; i < REQ; i++)
                if (exp_ready[i] || (!bus.req_valid_i[i] && $urandom_range(0, 1) == 1)) new_req(i);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
